multicycle_control_unit: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and write-back steps over several clocks.
- Drives the datapath muxes, register and memory write enables, and the 2-bit ALUOperation field consumed by the ALU control decoder.
- Waits on a memory ready handshake, so variable-latency instruction and data memory stall the sequence.

---
 rtl/multicycle_control_unit_pkg.sv | 60 ++++++
 rtl/multicycle_control_unit_control_output_decoder.sv | 76 +++++++
 rtl/multicycle_control_unit.sv | 97 +++++++++
 tb/tb_multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encoding, datapath select codes and the packed control word.
package multicycle_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B         = 2'b00;
  localparam logic [1:0] SRCB_FOUR      = 2'b01;
  localparam logic [1:0] SRCB_IMM       = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_operation;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_supported_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_control_output_decoder.sv
// Combinational decode of the current FSM state (plus the memory handshake)
// into the datapath control word; unknown states produce an all-zero word.
module control_output_decoder
  import multicycle_control_unit_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   illegal_op,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read      = 1'b1;
        ctrl.alu_src_b     = SRCB_FOUR;
        ctrl.alu_operation = ALU_ADD;
        ctrl.pc_source     = PCSRC_ALU;
        ctrl.ir_write      = mem_ready;
        ctrl.pc_write      = mem_ready;
      end
      // Precompute the branch target into ALUOut while the opcode is examined.
      S_DECODE: begin
        ctrl.alu_src_b     = SRCB_IMM_SHIFT;
        ctrl.alu_operation = ALU_ADD;
        ctrl.illegal_op    = illegal_op;
        ctrl.instr_done    = illegal_op;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_IMM;
        ctrl.alu_operation = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_operation = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_operation = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath: sequences each
// instruction through fetch/decode/execute/memory/write-back with memory stalls.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOperation,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       IllegalOp
);

  state_t state, state_next;
  ctrl_t  dec_ctrl, ctrl;
  logic   illegal_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  assign illegal_op = !is_supported_opcode(Opcode);

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      // A corrupted opcode here abandons the instruction rather than guessing.
      S_MEM_ADDR: begin
        if (Opcode == OP_LW)      state_next = S_MEM_READ;
        else if (Opcode == OP_SW) state_next = S_MEM_WRITE;
        else                      state_next = S_FETCH;
      end
      S_MEM_READ:  state_next = MemReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = MemReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  control_output_decoder u_decoder (
    .state      (state),
    .mem_ready  (MemReady),
    .illegal_op (illegal_op),
    .ctrl       (dec_ctrl)
  );

  // The register already sits in FETCH during reset, so gate the word to keep
  // every enable quiet until reset is released.
  always_comb begin
    ctrl = reset ? '0 : dec_ctrl;
  end

  assign PCWrite      = ctrl.pc_write;
  assign PCWriteCond  = ctrl.pc_write_cond;
  assign IorD         = ctrl.i_or_d;
  assign MemRead      = ctrl.mem_read;
  assign MemWrite     = ctrl.mem_write;
  assign IRWrite      = ctrl.ir_write;
  assign MemtoReg     = ctrl.mem_to_reg;
  assign RegDst       = ctrl.reg_dst;
  assign RegWrite     = ctrl.reg_write;
  assign ALUSrcA      = ctrl.alu_src_a;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign ALUOperation = ctrl.alu_operation;
  assign PCSource     = ctrl.pc_source;
  assign InstrDone    = ctrl.instr_done;
  assign IllegalOp    = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares the whole control word against hand-built values.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, IllegalOp;
  logic [1:0] ALUSrcB, ALUOperation, PCSource;

  int tests = 0;
  int fails = 0;

  multicycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .Opcode       (Opcode),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MemtoReg     (MemtoReg),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOperation (ALUOperation),
    .PCSource     (PCSource),
    .InstrDone    (InstrDone),
    .IllegalOp    (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOperation PCSource InstrDone IllegalOp
  logic [17:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOperation,
                PCSource, InstrDone, IllegalOp};

  localparam logic [17:0] E_ZERO       = 18'd0;
  localparam logic [17:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b1};
  localparam logic [17:0] E_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MEM_READ   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MW_WAIT    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MW_RDY     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_EXECUTE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_R_WB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1; Opcode = 6'b000000;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== E_ZERO) begin
        fails++;
        $display("[TB] FAIL reset_hold[%0d] got=%05h exp=%05h", i, obs, E_ZERO);
      end
      step();
    end
    reset = 1'b0; MemReady = 1'b0;
    #1;
    tests++;
    if (obs !== E_FETCH_WAIT) begin
      fails++;
      $display("[TB] FAIL reset_release got=%05h exp=%05h", obs, E_FETCH_WAIT);
    end
  endtask

  task automatic test_lw();
    logic [17:0] exp [6];
    logic        rdy [6];
    exp = '{E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_MEM_WB, E_FETCH_WAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      MemReady = rdy[i];
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL lw[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_lw_stall();
    logic [17:0] exp [7];
    logic        rdy [7];
    exp = '{E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_MEM_READ, E_MEM_WB, E_FETCH_WAIT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    Opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      MemReady = rdy[i];
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL lw_stall[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 6) step();
    end
  endtask

  task automatic test_rtype_stall();
    logic [17:0] exp [7];
    logic        rdy [7];
    exp = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_EXECUTE, E_R_WB, E_FETCH_WAIT};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      MemReady = rdy[i];
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL rtype[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 6) step();
    end
  endtask

  task automatic test_sw_stall();
    logic [17:0] exp [8];
    logic        rdy [8];
    exp = '{E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_MW_WAIT, E_MW_WAIT, E_MW_WAIT, E_MW_RDY, E_FETCH_WAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Opcode = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      MemReady = rdy[i];
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL sw[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 7) step();
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp [7];
    logic [5:0]  op  [7];
    exp = '{E_FETCH_RDY, E_DECODE, E_BRANCH, E_FETCH_RDY, E_DECODE, E_JUMP, E_FETCH_WAIT};
    op  = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
    for (int i = 0; i < 7; i++) begin
      Opcode   = op[i];
      MemReady = (i != 6);
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL beq_j[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 6) step();
    end
  endtask

  task automatic test_illegal();
    logic [17:0] exp [3];
    logic        rdy [3];
    exp = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_WAIT};
    rdy = '{1'b1, 1'b1, 1'b0};
    Opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      MemReady = rdy[i];
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL illegal[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 2) step();
    end
  endtask

  task automatic test_reset_mid_execute();
    logic [17:0] exp [3];
    exp = '{E_FETCH_RDY, E_DECODE, E_EXECUTE};
    Opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'b1;
      #1;
      tests++;
      if (obs !== exp[i]) begin
        fails++;
        $display("[TB] FAIL mid_reset_pre[%0d] got=%05h exp=%05h", i, obs, exp[i]);
      end
      if (i < 2) step();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (obs !== E_ZERO) begin
        fails++;
        $display("[TB] FAIL mid_reset_hold[%0d] got=%05h exp=%05h", i, obs, E_ZERO);
      end
      step();
    end
    reset = 1'b0; MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (obs !== E_FETCH_WAIT) begin
        fails++;
        $display("[TB] FAIL mid_reset_release[%0d] got=%05h exp=%05h", i, obs, E_FETCH_WAIT);
      end
      if (i < 1) step();
    end
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b0; Opcode = 6'b000000;
    test_reset();
    test_lw();
    test_lw_stall();
    test_rtype_stall();
    test_sw_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid_execute();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
